mul_share_arbiter: RTL and testbench

- Shares one external unsigned combinational multiplier between two requesters.
- Arbitrates each request round-robin or by fixed priority, drives the multiplier operands from registers, and captures the product.
- Returns the product with a requester tag over a valid/ready result port.
- Sits between the two operand producers and the multiplier instance; the multiplier itself stays outside this block.

---
 rtl/mul_share_arbiter.sv | 131 +++++++++++++
 tb/tb_mul_share_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Two-requester front end for a shared external combinational multiplier.
// Grants one request at a time, registers its operands, captures the product, returns it tagged.
module mul_share_arbiter #(
  parameter int W             = 3,
  parameter int PRIORITY_MODE = 0,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  output logic             req1_ready,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_s,
  output logic             res_valid,
  output logic             res_id,
  output logic [2*W-1:0]   res_s,
  input  logic             res_ready,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [2*W-1:0]      res_s_q, res_s_d;
  logic                res_id_q, res_id_d;
  logic                res_valid_q, res_valid_d;
  logic                last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    done_count_q, done_count_d;

  logic                grant, grant_vld, accept;
  logic [1:0][W-1:0]   req_a, req_b;

  assign req_a = {req1_a, req0_a};
  assign req_b = {req1_b, req0_b};

  // A tie goes to whoever did not win last time, unless fixed priority is selected.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid)
      grant = (PRIORITY_MODE != 0) ? 1'b0 : ~last_grant_q;
    else
      grant = ~req0_valid;
  end

  assign accept = (state_q == IDLE) && grant_vld && !rst;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = CALC;
      CALC:                   state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept && !grant;
    req1_ready = accept &&  grant;
    busy       = (state_q != IDLE);
  end

  always_comb begin
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    res_s_d      = res_s_q;
    res_id_d     = res_id_q;
    res_valid_d  = res_valid_q;
    last_grant_d = last_grant_q;
    done_count_d = done_count_q;
    case (state_q)
      IDLE: if (accept) begin
        mul_a_d      = req_a[grant];
        mul_b_d      = req_b[grant];
        res_id_d     = grant;
        last_grant_d = grant;
      end
      CALC: begin
        res_s_d     = mul_s;
        res_valid_d = 1'b1;
      end
      DONE: if (res_ready) begin
        res_valid_d  = 1'b0;
        done_count_d = done_count_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      res_s_q      <= '0;
      res_id_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      last_grant_q <= 1'b1;
      done_count_q <= '0;
    end else begin
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      res_s_q      <= res_s_d;
      res_id_q     <= res_id_d;
      res_valid_q  <= res_valid_d;
      last_grant_q <= last_grant_d;
      done_count_q <= done_count_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign res_s      = res_s_q;
  assign res_id     = res_id_q;
  assign res_valid  = res_valid_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Drives a round-robin instance (slot 0) and a fixed-priority instance (slot 1),
// checking each cycle against a transaction-level model of the sharing rules.
module tb_mul_share_arbiter;
  localparam int W = 3;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           r0v [2], r1v [2], rr [2];
  logic [W-1:0]   a0 [2], b0 [2], a1 [2], b1 [2];
  logic           r0rdy [2], r1rdy [2], rvld [2], rid [2], bsy [2];
  logic [W-1:0]   ma [2], mb [2];
  logic [2*W-1:0] ms [2], rs [2];
  logic [CNT_W-1:0] dc [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign ms[g] = {{W{1'b0}}, ma[g]} * {{W{1'b0}}, mb[g]};
    mul_share_arbiter #(.W(W), .PRIORITY_MODE(g), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(r0v[g]), .req0_a(a0[g]), .req0_b(b0[g]), .req0_ready(r0rdy[g]),
      .req1_valid(r1v[g]), .req1_a(a1[g]), .req1_b(b1[g]), .req1_ready(r1rdy[g]),
      .mul_a(ma[g]), .mul_b(mb[g]), .mul_s(ms[g]),
      .res_valid(rvld[g]), .res_id(rid[g]), .res_s(rs[g]), .res_ready(rr[g]),
      .busy(bsy[g]), .done_count(dc[g])
    );
  end

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: one outstanding operation at most, its age in cycles since accept.
  bit       pend [2];
  int       age [2];
  bit       lastw [2];
  int       exp_s [2];
  bit       exp_id [2];
  int       m_a [2], m_b [2];
  int       cnt [2];
  int       accepts [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      pend[m] = 0; age[m] = 0; lastw[m] = 1; exp_s[m] = 0; exp_id[m] = 0;
      m_a[m] = 0; m_b[m] = 0; cnt[m] = 0;
    end
  endtask

  task automatic do_reset(input bit v0, input bit v1);
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      r0v[m] = v0; r1v[m] = v1; rr[m] = 1'b1;
    end
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("rst_rdy0", r0rdy[m], 0);
      chk("rst_rdy1", r1rdy[m], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      r0v[m] = 0; r1v[m] = 0;
      chk("rst_rvld", rvld[m], 0);
      chk("rst_res_s", rs[m], 0);
      chk("rst_mul_a", ma[m], 0);
      chk("rst_cnt", dc[m], 0);
    end
  endtask

  task automatic cyc(input int m, input bit v0, input int ia0, input int ib0,
                     input bit v1, input int ia1, input int ib1, input bit ready);
    bit e0, e1, win;
    r0v[m] = v0; a0[m] = W'(ia0); b0[m] = W'(ib0);
    r1v[m] = v1; a1[m] = W'(ia1); b1[m] = W'(ib1);
    rr[m] = ready;
    @(negedge clk);
    win = 0; e0 = 0; e1 = 0;
    if (!pend[m] && (v0 || v1)) begin
      if (v0 && v1) win = (m == 1) ? 1'b0 : ~lastw[m];
      else          win = !v0;
      e0 = !win; e1 = win;
    end
    chk("rdy0", r0rdy[m], e0);
    chk("rdy1", r1rdy[m], e1);
    chk("busy", bsy[m], pend[m]);
    chk("res_valid", rvld[m], pend[m] && age[m] >= 1);
    if (pend[m] && age[m] >= 1) begin
      chk("res_s", rs[m], exp_s[m]);
      chk("res_id", rid[m], exp_id[m]);
    end
    chk("mul_a", ma[m], m_a[m]);
    chk("mul_b", mb[m], m_b[m]);
    chk("done_count", dc[m], cnt[m]);
    @(posedge clk); #1;
    if (e0 || e1) begin
      pend[m] = 1; age[m] = 0; lastw[m] = win; exp_id[m] = win; accepts[m]++;
      m_a[m] = win ? ia1 : ia0;
      m_b[m] = win ? ib1 : ib0;
      exp_s[m] = m_a[m] * m_b[m];
    end else if (pend[m]) begin
      if (age[m] >= 1 && ready) begin
        pend[m] = 0; cnt[m] = (cnt[m] + 1) % 256;
      end else age[m]++;
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      r0v[m] = 0; r1v[m] = 0; rr[m] = 1; a0[m] = 0; b0[m] = 0; a1[m] = 0; b1[m] = 0;
      accepts[m] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    do_reset(0, 0);

    // single request from r0
    for (int i = 0; i < 4; i++) cyc(0, i == 0, 3, 5, 0, 0, 0, 1);
    chk("first_cnt", dc[0], 1);

    // continuous tie: alternates 6/49, one accept every third cycle
    accepts[0] = 0;
    for (int i = 0; i < 12; i++) cyc(0, 1, 2, 3, 1, 7, 7, 1);
    chk("rr_accepts", accepts[0], 4);

    // backpressure with r1 waiting
    cyc(0, 1, 4, 5, 1, 6, 3, 1);
    cyc(0, 0, 4, 5, 1, 6, 3, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 6, 3, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 6, 3, 1);

    // exhaustive sweep
    do_reset(0, 0);
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int k = 0; k < 3; k++) cyc(0, 1, a, b, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("sweep_cnt", dc[0], 64);

    // reset in CALC, then tie must go to r0
    cyc(0, 1, 5, 5, 0, 0, 0, 1);
    cyc(0, 0, 5, 5, 1, 1, 1, 1);
    cyc(0, 0, 5, 5, 1, 1, 1, 1);
    cyc(0, 1, 5, 5, 0, 0, 0, 1);
    do_reset(0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 2, 2, 1, 3, 3, 1);
    // reset in DONE with res_valid high
    cyc(0, 0, 0, 0, 1, 4, 4, 0);
    cyc(0, 0, 0, 0, 1, 4, 4, 0);
    chk("done_rvld", rvld[0], 1);
    do_reset(1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 6, 7, 1, 5, 2, 1);

    // random round-robin
    for (int i = 0; i < 1500; i++)
      cyc(0, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
          1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
          1'($urandom_range(0, 1)));

    // fixed priority
    do_reset(0, 0);
    accepts[1] = 0;
    for (int i = 0; i < 12; i++) cyc(1, 1, 3, 4, 1, 7, 6, 1);
    chk("prio_accepts", accepts[1], 4);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 7, 6, 1);
    for (int i = 0; i < 1500; i++)
      cyc(1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
          1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
          1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
